// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: sequencer for the ID/EX boundary.
// It inserts load-use bubbles, flushes on MEM redirects, and freezes the
// pipeline after fin reaches WB. All outputs are Mealy; state and counters
// are registered.
module idex_hazard_ctrl #(
  parameter int LDSTALL = 1,
  parameter int CWIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_usesrt,
  input  logic              ex_memrd,
  input  logic [4:0]        ex_rt,
  input  logic              mem_redir,
  input  logic              wb_fin,
  output logic              pcwrite,
  output logic              ifidwrite,
  output logic              ifidflush,
  output logic              idexbubble,
  output logic              exmemflush,
  output logic              halted,
  output logic [CWIDTH-1:0] stallcnt,
  output logic [CWIDTH-1:0] flushcnt
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  // Bubbles still owed after the first one, which is inserted in RUN.
  localparam logic [3:0] REM_INIT = 4'(LDSTALL - 1);

  state_t      state, state_nx;
  logic [3:0]  rem, rem_nx;
  logic        hazard;
  logic        stall_inc, flush_inc;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CWIDTH-1){1'b0}}, 1'b1};
  endfunction

  // A load in EX whose (non-r0) destination feeds a source of the ID instruction.
  assign hazard = ex_memrd && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_usesrt && (ex_rt == id_rt)));

  // Next-state and Mealy outputs; priority fin > redirect > stall > normal.
  always_comb begin
    pcwrite    = 1'b1;
    ifidwrite  = 1'b1;
    ifidflush  = 1'b0;
    idexbubble = 1'b0;
    exmemflush = 1'b0;
    halted     = 1'b0;
    state_nx   = state;
    rem_nx     = rem;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (rst) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      ifidflush  = 1'b1;
      idexbubble = 1'b1;
      exmemflush = 1'b1;
      state_nx   = RUN;
      rem_nx     = 4'd0;
    end else if (state == HALT) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexbubble = 1'b1;
      exmemflush = 1'b1;
      halted     = 1'b1;
    end else if (wb_fin) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexbubble = 1'b1;
      exmemflush = 1'b1;
      state_nx   = HALT;
      rem_nx     = 4'd0;
    end else if (mem_redir) begin
      // Redirect wins over any pending or new load-use stall.
      ifidflush  = 1'b1;
      idexbubble = 1'b1;
      exmemflush = 1'b1;
      flush_inc  = 1'b1;
      state_nx   = RUN;
      rem_nx     = 4'd0;
    end else if (state == STALL) begin
      // Hazard is not re-evaluated; just drain the remaining bubbles.
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexbubble = 1'b1;
      stall_inc  = 1'b1;
      rem_nx     = rem - 4'd1;
      if (rem == 4'd1) state_nx = RUN;
    end else if (hazard) begin
      pcwrite    = 1'b0;
      ifidwrite  = 1'b0;
      idexbubble = 1'b1;
      stall_inc  = 1'b1;
      if (LDSTALL > 1) begin
        state_nx = STALL;
        rem_nx   = REM_INIT;
      end
    end
  end

  // State, bubble down-counter and saturating event counters.
  always_ff @(posedge clk) begin
    state <= state_nx;
    rem   <= rem_nx;
    if (rst) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (stall_inc) stallcnt <= sat_inc(stallcnt);
      if (flush_inc) flushcnt <= sat_inc(flushcnt);
    end
  end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl. Three instances share the inputs:
// LDSTALL=1/CWIDTH=16, LDSTALL=3/CWIDTH=16 and LDSTALL=1/CWIDTH=2.
module tb_idex_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_usesrt, ex_memrd, mem_redir, wb_fin;

  logic a_pcw, a_ifw, a_iff, a_bub, a_exf, a_hlt;
  logic [15:0] a_scnt, a_fcnt;
  logic b_pcw, b_ifw, b_iff, b_bub, b_exf, b_hlt;
  logic [15:0] b_scnt, b_fcnt;
  logic c_pcw, c_ifw, c_iff, c_bub, c_exf, c_hlt;
  logic [1:0] c_scnt, c_fcnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  idex_hazard_ctrl #(.LDSTALL(1), .CWIDTH(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usesrt(id_usesrt),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .mem_redir(mem_redir), .wb_fin(wb_fin),
    .pcwrite(a_pcw), .ifidwrite(a_ifw), .ifidflush(a_iff), .idexbubble(a_bub),
    .exmemflush(a_exf), .halted(a_hlt), .stallcnt(a_scnt), .flushcnt(a_fcnt));

  idex_hazard_ctrl #(.LDSTALL(3), .CWIDTH(16)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usesrt(id_usesrt),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .mem_redir(mem_redir), .wb_fin(wb_fin),
    .pcwrite(b_pcw), .ifidwrite(b_ifw), .ifidflush(b_iff), .idexbubble(b_bub),
    .exmemflush(b_exf), .halted(b_hlt), .stallcnt(b_scnt), .flushcnt(b_fcnt));

  idex_hazard_ctrl #(.LDSTALL(1), .CWIDTH(2)) u_c (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usesrt(id_usesrt),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .mem_redir(mem_redir), .wb_fin(wb_fin),
    .pcwrite(c_pcw), .ifidwrite(c_ifw), .ifidflush(c_iff), .idexbubble(c_bub),
    .exmemflush(c_exf), .halted(c_hlt), .stallcnt(c_scnt), .flushcnt(c_fcnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs shortly after a posedge; outputs are sampled mid-cycle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                       input logic memrd, input logic [4:0] exrt,
                       input logic redir, input logic fin);
    id_rs = rs; id_rt = rt; id_usesrt = usesrt;
    ex_memrd = memrd; ex_rt = exrt; mem_redir = redir; wb_fin = fin;
    #2;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    // Outputs while reset is asserted
    chk("rst_pcwrite",    {31'd0, a_pcw}, 32'd0);
    chk("rst_ifidwrite",  {31'd0, a_ifw}, 32'd0);
    chk("rst_ifidflush",  {31'd0, a_iff}, 32'd1);
    chk("rst_idexbubble", {31'd0, a_bub}, 32'd1);
    chk("rst_exmemflush", {31'd0, a_exf}, 32'd1);
    chk("rst_halted",     {31'd0, a_hlt}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    chk("idle_pcwrite",    {31'd0, a_pcw}, 32'd1);
    chk("idle_ifidwrite",  {31'd0, a_ifw}, 32'd1);
    chk("idle_ifidflush",  {31'd0, a_iff}, 32'd0);
    chk("idle_idexbubble", {31'd0, a_bub}, 32'd0);
    chk("idle_exmemflush", {31'd0, a_exf}, 32'd0);
    chk("idle_halted",     {31'd0, a_hlt}, 32'd0);
    chk("idle_stallcnt",   {16'd0, a_scnt}, 32'd0);
    chk("idle_flushcnt",   {16'd0, a_fcnt}, 32'd0);

    // Load-use on Rs, LDSTALL=1: exactly one bubble cycle
    step();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("lu_rs_pcwrite",    {31'd0, a_pcw}, 32'd0);
    chk("lu_rs_ifidwrite",  {31'd0, a_ifw}, 32'd0);
    chk("lu_rs_idexbubble", {31'd0, a_bub}, 32'd1);
    chk("lu_rs_exmemflush", {31'd0, a_exf}, 32'd0);
    step();
    idle();
    chk("lu_rs_after_pcwrite", {31'd0, a_pcw}, 32'd1);
    chk("lu_rs_after_bubble",  {31'd0, a_bub}, 32'd0);
    chk("lu_rs_stallcnt",      {16'd0, a_scnt}, 32'd1);

    // Rt match ignored when ID does not read Rt; r0 never stalls
    do_reset();
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("rt_unused_pcwrite", {31'd0, a_pcw}, 32'd1);
    step();
    drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("r0_pcwrite", {31'd0, a_pcw}, 32'd1);
    step();
    drive(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    chk("lu_rt_pcwrite", {31'd0, a_pcw}, 32'd0);
    step();
    idle();
    chk("filter_stallcnt", {16'd0, a_scnt}, 32'd1);

    // LDSTALL=3: two stall bubbles, then a redirect aborts the stall
    do_reset();
    drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    chk("l3_b1_pcwrite", {31'd0, b_pcw}, 32'd0);
    chk("l3_b1_bubble",  {31'd0, b_bub}, 32'd1);
    step();
    idle();
    chk("l3_b2_pcwrite", {31'd0, b_pcw}, 32'd0);
    chk("l3_b2_bubble",  {31'd0, b_bub}, 32'd1);
    step();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("l3_redir_pcwrite",   {31'd0, b_pcw}, 32'd1);
    chk("l3_redir_ifidwrite", {31'd0, b_ifw}, 32'd1);
    chk("l3_redir_ifidflush", {31'd0, b_iff}, 32'd1);
    chk("l3_redir_bubble",    {31'd0, b_bub}, 32'd1);
    chk("l3_redir_exmemflush",{31'd0, b_exf}, 32'd1);
    step();
    idle();
    chk("l3_run_pcwrite", {31'd0, b_pcw}, 32'd1);
    chk("l3_run_bubble",  {31'd0, b_bub}, 32'd0);
    chk("l3_stallcnt",    {16'd0, b_scnt}, 32'd2);
    chk("l3_flushcnt",    {16'd0, b_fcnt}, 32'd1);

    // fin together with redirect: fin wins, then frozen until reset
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("fin_pcwrite",    {31'd0, a_pcw}, 32'd0);
    chk("fin_ifidwrite",  {31'd0, a_ifw}, 32'd0);
    chk("fin_ifidflush",  {31'd0, a_iff}, 32'd0);
    chk("fin_bubble",     {31'd0, a_bub}, 32'd1);
    chk("fin_exmemflush", {31'd0, a_exf}, 32'd1);
    chk("fin_halted",     {31'd0, a_hlt}, 32'd0);
    step();
    idle();
    chk("halt_halted",    {31'd0, a_hlt}, 32'd1);
    chk("halt_pcwrite",   {31'd0, a_pcw}, 32'd0);
    chk("halt_ifidflush", {31'd0, a_iff}, 32'd0);
    chk("halt_flushcnt",  {16'd0, a_fcnt}, 32'd0);
    step();
    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("halt_ignore_halted",  {31'd0, a_hlt}, 32'd1);
    chk("halt_ignore_pcwrite", {31'd0, a_pcw}, 32'd0);
    step();
    idle();
    chk("halt_stallcnt", {16'd0, a_scnt}, 32'd0);
    chk("halt_flushcnt2",{16'd0, a_fcnt}, 32'd0);
    chk("halt_sticky",   {31'd0, a_hlt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, a_hlt}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    chk("halt_exit_pcwrite", {31'd0, a_pcw}, 32'd1);
    chk("halt_exit_halted",  {31'd0, a_hlt}, 32'd0);

    // CWIDTH=2: five hazards saturate the stall counter at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
      step();
    end
    idle();
    chk("sat_c_stallcnt", {30'd0, c_scnt}, 32'd3);
    chk("sat_a_stallcnt", {16'd0, a_scnt}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
